// File: rtl/sync_bank_multimode_pkg.sv
// sync_bank_pkg: shared types and limits for the multi-mode synchroniser bank.
//   mode_t      - operating mode encoding as seen on the 2-bit mode port
//   stb_state_t - strobe-capture handshake states
//   STAGES_MIN/STAGES_MAX and clamp_stages() bound the synchroniser depth
package sync_bank_pkg;

    typedef enum logic [1:0] {
        MODE_REG  = 2'd0,
        MODE_SYNC = 2'd1,
        MODE_FILT = 2'd2,
        MODE_STB  = 2'd3
    } mode_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } stb_state_t;

    localparam int unsigned STAGES_MIN = 2;
    localparam int unsigned STAGES_MAX = 4;

    // Keeps an out-of-range STAGES override from building a degenerate chain.
    function automatic int unsigned clamp_stages(input int unsigned s);
        if (s < STAGES_MIN) return STAGES_MIN;
        if (s > STAGES_MAX) return STAGES_MAX;
        return s;
    endfunction

endpackage

// File: rtl/sync_bank_multimode_chain.sv
// sync_chain: plain flop chain with asynchronous active-low reset.
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, clears every stage
//   d_i   - WIDTH-bit asynchronous input
//   q_o   - output of the last of STAGES flops
module sync_chain
    import sync_bank_pkg::*;
#(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int unsigned i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/sync_bank_multimode.sv
// sync_bank_multimode: multi-mode input synchroniser bank.
// Brings an asynchronous bus and strobe into the clk domain in one of four
// modes (bare register, N-stage sync, sync + per-bit glitch filter,
// strobe-qualified capture) and adds per-bit edge pulses and a valid pulse.
//   clk       - destination clock
//   rst_n     - asynchronous active-low reset
//   ena       - block enable; low freezes sync_out and zeroes pulses/busy
//   mode      - 0=REG, 1=SYNC, 2=FILT, 3=STB
//   async_in  - WIDTH-bit asynchronous data bus
//   async_stb - asynchronous capture strobe (STB mode only)
//   sync_out  - synchronised / captured data
//   rise/fall - per-bit 1-cycle pulses for sync_out 0->1 / 1->0
//   valid     - 1-cycle pulse: sync_out changed, or capture done in STB mode
//   busy      - STB handshake in progress
module sync_bank_multimode
    import sync_bank_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned STAGES   = 2,
    parameter int unsigned FILT_LEN = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] async_in,
    input  logic             async_stb,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             valid,
    output logic             busy
);

    localparam int unsigned CHAIN_LEN = clamp_stages(STAGES);
    localparam int unsigned CNT_W     = $clog2(FILT_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_TAKE = CNT_W'(FILT_LEN - 1);

    // Data path: CHAIN_LEN-1 flops in the chain plus data_s_q. In SYNC mode
    // sync_out itself acts as the last synchroniser flop (latency STAGES),
    // while the filter looks at the full-depth data_s_q.
    logic [WIDTH-1:0] data_pre;
    logic [WIDTH-1:0] data_s_q;
    logic             stb_s;
    logic             stb_q;

    sync_chain #(
        .WIDTH  (WIDTH),
        .STAGES (CHAIN_LEN - 1)
    ) u_data_chain (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (async_in),
        .q_o   (data_pre)
    );

    sync_chain #(
        .WIDTH  (1),
        .STAGES (CHAIN_LEN)
    ) u_stb_chain (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (async_stb),
        .q_o   (stb_s)
    );

    mode_t                        mode_q;
    stb_state_t                   state_q, state_d;
    logic [WIDTH-1:0]             sync_q, sync_d;
    logic [WIDTH-1:0]             rise_q, rise_d;
    logic [WIDTH-1:0]             fall_q, fall_d;
    logic                         valid_q, valid_d;
    logic                         busy_q, busy_d;
    logic [WIDTH-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic                         capture;

    always_comb begin
        sync_d  = sync_q;
        cnt_d   = '0;
        state_d = IDLE;
        capture = 1'b0;

        // Disable and mode-change both act as a flush: sync_out holds,
        // counters and FSM restart; disable takes priority.
        if (ena && (mode_t'(mode) == mode_q)) begin
            unique case (mode_q)
                MODE_REG: begin
                    sync_d = async_in;
                end
                MODE_SYNC: begin
                    sync_d = data_pre;
                end
                MODE_FILT: begin
                    for (int unsigned i = 0; i < WIDTH; i++) begin
                        if (data_s_q[i] == sync_q[i]) begin
                            cnt_d[i] = '0;
                        end else if (cnt_q[i] == CNT_TAKE) begin
                            sync_d[i] = data_s_q[i];
                            cnt_d[i]  = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                end
                MODE_STB: begin
                    unique case (state_q)
                        IDLE: begin
                            if (stb_s && !stb_q) begin
                                sync_d  = async_in;
                                capture = 1'b1;
                                state_d = HOLD;
                            end
                        end
                        HOLD: begin
                            state_d = stb_s ? HOLD : IDLE;
                        end
                    endcase
                end
            endcase
        end

        rise_d  = sync_d & ~sync_q;
        fall_d  = sync_q & ~sync_d;
        valid_d = capture | (|(rise_d | fall_d));
        busy_d  = (state_d == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_s_q <= '0;
            stb_q    <= 1'b0;
            mode_q   <= MODE_REG;
            state_q  <= IDLE;
            sync_q   <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            data_s_q <= data_pre;
            stb_q    <= stb_s;
            mode_q   <= mode_t'(mode);
            state_q  <= state_d;
            sync_q   <= sync_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
        end
    end

    assign sync_out = sync_q;
    assign rise     = rise_q;
    assign fall     = fall_q;
    assign valid    = valid_q;
    assign busy     = busy_q;

endmodule

// File: doc/sync_bank_multimode.md
Name: sync_bank_multimode

Overview:
- Parametrised, multi-mode input synchroniser bank: the successor to the fixed 8-bit, 4-mode TT synchroniser.
- Brings a WIDTH-bit asynchronous bus and an asynchronous strobe into the clk domain.
- Modes: bare register, N-stage synchroniser, synchroniser plus per-bit glitch filter, strobe-qualified bus capture (multi-cycle-path handshake).
- Sits directly behind the ui_in/uio_in pads; adds per-bit edge pulses and a change/capture valid.

Parameters:
- WIDTH, 8, bus width (1..32).
- STAGES, 2, synchroniser flop depth (2..4).
- FILT_LEN, 3, consecutive stable cycles required by the glitch filter (1..15).

Ports:
- clk  in  1  destination clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  block enable; 0 freezes outputs.
- mode  in  2  0=REG, 1=SYNC, 2=FILT, 3=STB.
- async_in  in  WIDTH  asynchronous data bus.
- async_stb  in  1  asynchronous capture strobe (mode 3 only).
- sync_out  out  WIDTH  synchronised/captured data.
- rise  out  WIDTH  per-bit 1-cycle pulse, sync_out bit 0->1.
- fall  out  WIDTH  per-bit 1-cycle pulse, sync_out bit 1->0.
- valid  out  1  1-cycle pulse: sync_out changed (modes 0-2) or capture done (mode 3).
- busy  out  1  mode 3 handshake in progress.

Behaviour:
- Clock and reset: single clock clk. Reset is asynchronous and active-low on rst_n. All flops clear on reset: sync_out, rise, fall, valid, busy, chains, filter counters, mode_q = 0; FSM = IDLE.
- Chains: the data chain (STAGES x WIDTH) and strobe chain (STAGES x 1) clock every cycle, independent of mode and ena.
- sync_out next value per mode:
  - REG: async_in, 1 register. Latency 1.
  - SYNC: last chain stage. Latency STAGES.
  - FILT: per bit, a counter cnt[i] (width clog2(FILT_LEN+1)).
    - Chain output == sync_out[i]: cnt clears.
    - Otherwise cnt increments; when it reaches FILT_LEN-1, sync_out[i] takes the chain value and cnt clears.
    - Latency STAGES+FILT_LEN. Pulses shorter than FILT_LEN cycles never reach sync_out.
  - STB: sync_out loads raw async_in on capture only. The protocol guarantees the bus is stable while stb is high.
- Strobe FSM (mode 3), with stb_s = last strobe stage and stb_q = its 1-cycle delay:
  - IDLE: stb_s & ~stb_q -> capture async_in into sync_out, valid=1 same cycle, go HOLD.
  - HOLD: busy=1; stay until stb_s==0, then IDLE.
  - Capture latency: STAGES+1 cycles from async_stb rising to sync_out/valid.
  - A strobe high shorter than 1 clk period may be missed (documented, not flagged).
  - A new rising edge while in HOLD cannot occur, because HOLD exits only when stb_s is low.
- rise/fall/valid: registered alongside sync_out, computed from next vs current value, so they assert in the same cycle sync_out shows the new value.
  - Modes 0-2: valid = OR of rise|fall.
  - Mode 3: valid fires on capture even if the data is unchanged.
- Mode change (mode != mode_q): one flush cycle.
  - sync_out holds; rise/fall/valid = 0.
  - Filter counters clear; FSM -> IDLE, busy = 0.
  - The new mode takes effect on the next cycle.
- ena = 0:
  - sync_out holds; rise/fall/valid/busy = 0.
  - FSM forced IDLE; filter counters clear.
  - On ena rising, no pulse is generated for the hold period.
- Reset mid-capture: asynchronous clear. No valid is emitted for the interrupted capture.
- Simultaneous events: mode change takes priority over capture/filter update in the same cycle; ena=0 takes priority over both.

Decomposition:
- Package sync_bank_pkg:
  - mode_t enum (MODE_REG=2'd0, MODE_SYNC=2'd1, MODE_FILT=2'd2, MODE_STB=2'd3).
  - stb_state_t (IDLE, HOLD).
  - Parameter range limits (STAGES_MIN=2, STAGES_MAX=4).
- Sub-module sync_chain #(WIDTH, STAGES): plain flop chain with async reset. Instantiated twice: data (WIDTH) and strobe (1).

Test Plan (WIDTH=8, STAGES=2, FILT_LEN=3):
- Reset: rst_n=0 with async_in=8'hFF -> sync_out=8'h00, valid=0, busy=0; asynchronous clear mid-clock verified.
- Mode 0/1 latency: async_in 8'h00->8'h55 -> sync_out=8'h55 after 1 cycle (mode 0) / 2 cycles (mode 1); rise=8'h55 and valid=1 for exactly that cycle.
- Mode 2 filter:
  - A 2-cycle glitch on bit0 -> sync_out unchanged, rise=0.
  - A held 8'h0F -> sync_out=8'h0F exactly 5 cycles later, valid pulse.
- Mode 3 capture:
  - async_in=8'hA5, async_stb high 4 cycles -> sync_out=8'hA5 and valid 3 cycles after stb rise.
  - busy high until 2 cycles after stb fall.
  - Bus changes to 8'h00 while busy -> sync_out stays 8'hA5.
- Mode switch/ena:
  - Mode 1->2 while async_in toggles -> flush cycle with no pulses, filter restarts at 0.
  - ena=0 for 10 cycles with async_in 8'h33 -> outputs frozen; after re-enable, sync_out reaches 8'h33 with one valid.
- Random regression: random mode/stb/async_in every 5 cycles for 50 iterations. Scoreboard model checks sync_out, rise, fall, valid and busy each cycle.
